sc_psum_unit: RTL and testbench
===============================

# sc_psum_unit

Leaf-level hard-decision and partial-sum unit of the SC polar decoder. It consumes the leaf LLR produced by the f/g processing-element array, decides each bit û_i (forced to 0 when frozen), and streams decisions out. It maintains the per-stage partial-sum store that supplies the `u_sum` control bit to the g nodes. It runs one bit at a time with a ready/valid handshake and a multi-cycle partial-sum update FSM.

## Interface
- `N_LOG_MAX`, default 9: log2 of the maximum code length; N_MAX = 512.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a codeword; honoured only in IDLE.
- `n_log` in 4: log2 N, sampled on `start`; clamped to the range 1..N_LOG_MAX.
- `llr_valid` in 1: `llr_in` and `frozen` are valid.
- `llr_in` in 13: signed two's-complement leaf LLR for bit i.
- `frozen` in 1: bit i is frozen.
- `llr_ready` out 1: the unit accepts a leaf LLR this cycle.
- `u_valid` out 1: one-cycle pulse; `u_hat` and `u_idx` are valid.
- `u_hat` out 1: decided bit.
- `u_idx` out N_LOG_MAX: index i of the decided bit.
- `psum_stage` in 4: partial-sum read stage s, where s < n_log.
- `psum_idx` in N_LOG_MAX-1: element j, where j < 2^s.
- `psum_bit` out 1: PS_s[j], registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the final bit's update.

## Operation
- Storage: PS_s for s = 0..N_LOG_MAX-1, with 2^s bits in stage s (N_MAX-1 flops total). A combine register `v` is N_MAX/2 bits wide. Counters hold i (bit index) and s (current stage).
- FSM states: IDLE, WAIT, UPD, DONE.
- IDLE, on `start`: latch the clamped `n_log`, clear all PS to 0, set i=0, go to WAIT. `start` in any other state is ignored.
- WAIT: `llr_ready`=1.
  - On `llr_valid` & `llr_ready`: u = frozen ? 0 : llr_in[12]. LLR 0 therefore decides 0.
  - Register `u_hat`=u and `u_idx`=i, and pulse `u_valid`.
  - Load v[0]=u and s=0, then go to UPD.
- UPD: one stage per cycle.
  - If i[s]==0: write PS_s[0..2^s-1] = v[0..2^s-1]. Then i=i+1 and go to WAIT.
  - Else if s == n_log-1: go to DONE. This happens only when i = N-1.
  - Else combine: the new v has length 2^(s+1), with v'[k] = PS_s[k] ^ v[k] and v'[2^s+k] = v[k] for k < 2^s. Then s=s+1 and stay in UPD.
- DONE: pulse `done`, then return to IDLE. PS contents are held until the next `start`.
- Partial-sum read: `psum_bit` <= PS_{psum_stage}[psum_idx] every cycle, in any state.
  - Out-of-range stage or index returns 0.
  - A read of an entry written in the same cycle returns the old value.
- Reset, including mid-codeword: return to IDLE immediately. All PS, v, counters and outputs are cleared.

## Timing
- Reset values: `llr_ready`, `u_valid`, `u_hat`, `u_idx`, `psum_bit`, `busy` and `done` are all 0.
- `u_valid` is asserted the cycle after the LLR handshake. It coincides with the first UPD cycle.
- UPD length for bit i:
  - t+1 cycles, where t is the number of trailing ones of i.
  - For i = N-1 it is n_log cycles.
  - `llr_ready` is low throughout UPD.
- Next-bit acceptance: `llr_ready` returns high the cycle after the storing UPD cycle. Minimum spacing between accepted LLRs is 2 cycles (even i).
- Partial-sum visibility: a PS entry written in an UPD cycle is readable via `psum_bit` two cycles later (address in the next cycle, data the cycle after).
- `done` is high the cycle after the final UPD cycle. `busy` falls the cycle after that.
- Latency from `start` to `llr_ready`: 1 cycle.

## Test plan
- Basic N=4 decode:
  - Stimulus: n_log=2, no frozen bits, LLRs -5, 3, -1, -7.
  - Required: `u_hat` = 1,0,1,1 with `u_idx` = 0..3. UPD lengths 1,2,1,2 cycles.
  - After bit 1: PS_1 = [1,0] (j=0 → 1, j=1 → 0). After bit 2: PS_0[0] = 1.
  - `done` pulses once.
- Decision rules:
  - frozen=1 with LLR -100 → `u_hat`=0.
  - LLR 0 → 0.
  - LLR 13'h1000 (-4096) → 1.
  - LLR 13'h0FFF → 0.
- N=8 update timing: bit 3 takes 3 UPD cycles; bit 7 takes 3 cycles and then `done`. All `llr_ready` gaps are checked against a reference model of PS after every bit.
- N=512 random stress: random LLRs and frozen mask, with `llr_valid` stalls. After each bit, every PS entry matches the software polar-encoding model. Exactly 512 `u_valid` pulses.
- Corner cases:
  - `start` asserted mid-codeword is ignored.
  - `rst_n` low during UPD clears all outputs asynchronously. The next `start` decodes correctly.
  - n_log=0 behaves as 1; n_log=12 behaves as 9.

Source files
------------

// File: rtl/sc_psum_unit.sv
// sc_psum_unit
// Leaf decision and partial-sum unit of an SC polar decoder. Each accepted
// leaf LLR is turned into a hard decision (0 when the bit is frozen). The
// decision is then folded into the per-stage partial-sum store, one stage
// per cycle, to keep the u_sum bits that the g nodes read.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start, n_log             begin a codeword of length 2^n_log (IDLE only)
//   llr_valid/llr_ready      leaf LLR handshake carrying llr_in and frozen
//   u_valid, u_hat, u_idx    one-cycle decision strobe with bit and index
//   psum_stage, psum_idx     partial-sum read address (stage s, element j)
//   psum_bit                 registered PS_s[j], or 0 when out of range
//   busy, done               activity flag and end-of-codeword pulse
module sc_psum_unit #(
    parameter int N_LOG_MAX = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           n_log,
    input  logic                 llr_valid,
    input  logic [12:0]          llr_in,
    input  logic                 frozen,
    output logic                 llr_ready,
    output logic                 u_valid,
    output logic                 u_hat,
    output logic [N_LOG_MAX-1:0] u_idx,
    input  logic [3:0]           psum_stage,
    input  logic [N_LOG_MAX-2:0] psum_idx,
    output logic                 psum_bit,
    output logic                 busy,
    output logic                 done
);

    localparam int N_MAX = 1 << N_LOG_MAX;
    localparam int V_W   = N_MAX / 2;
    localparam int PS_W  = N_MAX - 1;
    localparam int AW    = N_LOG_MAX + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_UPD, ST_DONE} state_t;

    state_t               state_reg;
    logic [3:0]           n_log_reg;
    logic [3:0]           s_reg;
    logic [N_LOG_MAX-1:0] i_reg;
    logic [V_W-1:0]       v_reg;
    logic [V_W-1:0]       v_next;
    logic [PS_W-1:0]      ps_flat;
    logic [3:0]           n_log_clamped;
    logic                 dec_bit;
    logic                 clear_ps;
    logic                 store_now;
    logic [AW-1:0]        rd_len;
    logic [AW-1:0]        rd_addr;
    logic                 rd_ok;

    always_comb begin
        n_log_clamped = n_log;
        if (n_log == 4'd0)
            n_log_clamped = 4'd1;
        else if (n_log > 4'(N_LOG_MAX))
            n_log_clamped = 4'(N_LOG_MAX);
    end

    // Sign bit is the hard decision, so an LLR of exactly 0 decides 0.
    assign dec_bit   = !frozen && llr_in[12];
    assign clear_ps  = (state_reg == ST_IDLE) && start;
    assign store_now = (state_reg == ST_UPD) && !i_reg[s_reg];

    // Stage s lives at flat offset 2^s - 1 so the read port can address all
    // stages with a single index.
    genvar gi;
    generate
        for (gi = 0; gi < N_LOG_MAX; gi++) begin : g_stage
            localparam int LEN = 1 << gi;
            logic [LEN-1:0] ps_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ps_reg <= '0;
                else if (clear_ps)
                    ps_reg <= '0;
                else if (store_now && (s_reg == 4'(gi)))
                    ps_reg <= v_reg[LEN-1:0];
            end

            assign ps_flat[LEN-1 +: LEN] = ps_reg;
        end
    endgenerate

    // Combine step: the block of decisions grows to 2^(s+1) as
    // [PS_s ^ v, v]. The last stage never combines, so N_LOG_MAX-1 cases.
    always_comb begin
        v_next = v_reg;
        for (int st = 0; st < N_LOG_MAX - 1; st++) begin
            if (s_reg == 4'(st)) begin
                for (int k = 0; k < (1 << st); k++) begin
                    v_next[k]             = ps_flat[(1 << st) - 1 + k] ^ v_reg[k];
                    v_next[(1 << st) + k] = v_reg[k];
                end
            end
        end
    end

    always_comb begin
        rd_len  = {{(AW-1){1'b0}}, 1'b1} << psum_stage;
        rd_ok   = (psum_stage < 4'(N_LOG_MAX)) && (AW'(psum_idx) < rd_len);
        rd_addr = rd_len - {{(AW-1){1'b0}}, 1'b1} + AW'(psum_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            psum_bit <= 1'b0;
        else
            psum_bit <= rd_ok ? ps_flat[rd_addr[N_LOG_MAX-1:0]] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            n_log_reg <= 4'd0;
            s_reg     <= 4'd0;
            i_reg     <= '0;
            v_reg     <= '0;
            llr_ready <= 1'b0;
            u_valid   <= 1'b0;
            u_hat     <= 1'b0;
            u_idx     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            u_valid <= 1'b0;
            done    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        n_log_reg <= n_log_clamped;
                        i_reg     <= '0;
                        s_reg     <= 4'd0;
                        v_reg     <= '0;
                        llr_ready <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (llr_valid) begin
                        u_hat     <= dec_bit;
                        u_idx     <= i_reg;
                        u_valid   <= 1'b1;
                        v_reg     <= {{(V_W-1){1'b0}}, dec_bit};
                        s_reg     <= 4'd0;
                        llr_ready <= 1'b0;
                        state_reg <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    if (!i_reg[s_reg]) begin
                        // Left half of a larger block: park it for later.
                        i_reg     <= i_reg + N_LOG_MAX'(1);
                        llr_ready <= 1'b1;
                        state_reg <= ST_WAIT;
                    end else if (s_reg == n_log_reg - 4'd1) begin
                        // Only i = N-1 reaches the top with all ones.
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        v_reg <= v_next;
                        s_reg <= s_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_psum_unit.sv
// Bench for sc_psum_unit: table vectors for the N=4 / N=8 cases, a random
// N=512 run, and hand-written reset / start corner sequences. The reference
// keeps the decision history and re-encodes the relevant block with the
// polar transform after every bit.
module tb_sc_psum_unit;

    localparam int NLM = 9;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [3:0]     n_log = 4'd0;
    logic           llr_valid = 1'b0;
    logic [12:0]    llr_in = 13'd0;
    logic           frozen = 1'b0;
    logic           llr_ready;
    logic           u_valid;
    logic           u_hat;
    logic [NLM-1:0] u_idx;
    logic [3:0]     psum_stage = 4'd0;
    logic [NLM-2:0] psum_idx = '0;
    logic           psum_bit;
    logic           busy;
    logic           done;

    int total = 0;
    int bad = 0;
    int uv_count = 0;

    always #5 clk = ~clk;

    sc_psum_unit #(.N_LOG_MAX(NLM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_log(n_log),
        .llr_valid(llr_valid), .llr_in(llr_in), .frozen(frozen),
        .llr_ready(llr_ready), .u_valid(u_valid), .u_hat(u_hat), .u_idx(u_idx),
        .psum_stage(psum_stage), .psum_idx(psum_idx), .psum_bit(psum_bit),
        .busy(busy), .done(done)
    );

    always @(negedge clk) if (u_valid === 1'b1) uv_count <= uv_count + 1;

    typedef struct {
        logic signed [12:0] llr;
        logic               frz;
        logic               exp_u;
        int                 exp_len;
    } vec_t;

    vec_t tab [0:11];

    // Reference state
    int m_nlog, m_n, m_i;
    bit u_hist [0:511];
    bit mps [0:NLM-1][0:255];

    function automatic vec_t mkv(input logic signed [12:0] l, input logic f,
                                 input logic u, input int len);
        vec_t r;
        r.llr = l; r.frz = f; r.exp_u = u; r.exp_len = len;
        return r;
    endfunction

    function automatic int trail_ones(input int v);
        int t = 0;
        while (((v >> t) & 1) == 1) t++;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic finish_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int s = 0; s < NLM; s++)
            for (int j = 0; j < 256; j++) mps[s][j] = 1'b0;
    endtask

    // After bit i the block of 2^t decisions ending at i (t = trailing ones)
    // is complete and becomes PS_t, polar-encoded.
    task automatic model_bit(input bit u);
        int t, len;
        bit x [0:255];
        u_hist[m_i] = u;
        if (m_i != m_n - 1) begin
            t = trail_ones(m_i);
            len = 1 << t;
            for (int k = 0; k < len; k++) x[k] = u_hist[m_i - len + 1 + k];
            for (int h = 1; h < len; h = h * 2)
                for (int b = 0; b < len; b += 2 * h)
                    for (int k = b; k < b + h; k++) x[k] = x[k] ^ x[k + h];
            for (int k = 0; k < len; k++) mps[t][k] = x[k];
        end
        m_i++;
    endtask

    task automatic read_ps(input int s, input int j, output logic b);
        psum_stage = 4'(s);
        psum_idx = 8'(j);
        tick;
        b = psum_bit;
    endtask

    task automatic check_stage(input int s);
        logic b;
        for (int j = 0; j < (1 << s); j++) begin
            read_ps(s, j, b);
            chk($sformatf("ps[%0d][%0d]", s, j), b, mps[s][j]);
        end
    endtask

    task automatic check_all;
        for (int s = 0; s < m_nlog; s++) check_stage(s);
    endtask

    task automatic do_start(input logic [3:0] nl);
        int nli;
        nli = nl;
        start = 1'b1;
        n_log = nl;
        tick;
        start = 1'b0;
        m_nlog = (nli == 0) ? 1 : ((nli > NLM) ? NLM : nli);
        m_n = 1 << m_nlog;
        m_i = 0;
        model_clear;
        chk("start_ready", llr_ready, 1);
        chk("start_busy", busy, 1);
    endtask

    task automatic handshake(input logic signed [12:0] llr, input logic frz, input int stall);
        int n = 0;
        repeat (stall) tick;
        llr_in = llr;
        frozen = frz;
        llr_valid = 1'b1;
        while (llr_ready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        if (llr_ready !== 1'b1) begin
            chk("llr_ready_wait", llr_ready, 1);
            finish_run;
        end
        tick;
        llr_valid = 1'b0;
    endtask

    task automatic send_bit(input logic signed [12:0] llr, input logic frz, input int stall,
                            output logic u_got, output int len);
        bit exp_u;
        int exp_len, idx;
        exp_u = frz ? 1'b0 : (llr < 0);
        idx = m_i;
        exp_len = (idx == m_n - 1) ? m_nlog : trail_ones(idx) + 1;
        handshake(llr, frz, stall);
        chk("u_valid", u_valid, 1);
        chk("u_hat", u_hat, exp_u);
        chk("u_idx", u_idx, idx);
        chk("ready_low_upd", llr_ready, 0);
        u_got = u_hat;
        len = 0;
        while (llr_ready !== 1'b1 && done !== 1'b1 && len < 20) begin
            tick;
            len++;
            if (len == 1) chk("u_valid_pulse", u_valid, 0);
        end
        chk($sformatf("upd_len[%0d]", idx), len, exp_len);
        if (idx == m_n - 1) begin
            chk("done", done, 1);
            chk("busy_in_done", busy, 1);
            tick;
            chk("done_pulse", done, 0);
            chk("busy_fall", busy, 0);
            chk("ready_idle", llr_ready, 0);
        end else begin
            chk("no_early_done", done, 0);
        end
        model_bit(exp_u);
        $display("bit %0d llr=%0d frozen=%0d u_hat=%0d upd=%0d", idx, llr, frz, u_got, len);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_llr_ready"}, llr_ready, 0);
        chk({tag, "_u_valid"}, u_valid, 0);
        chk({tag, "_u_hat"}, u_hat, 0);
        chk({tag, "_u_idx"}, u_idx, 0);
        chk({tag, "_psum_bit"}, psum_bit, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $finish;
    end

    initial begin
        logic ug, b;
        int ln, uv_base, t;
        logic signed [12:0] r;

        tab[0]  = mkv(-13'sd5,   1'b0, 1'b1, 1);
        tab[1]  = mkv(13'sd3,    1'b0, 1'b0, 2);
        tab[2]  = mkv(-13'sd1,   1'b0, 1'b1, 1);
        tab[3]  = mkv(-13'sd7,   1'b0, 1'b1, 2);
        tab[4]  = mkv(-13'sd100, 1'b1, 1'b0, 1);
        tab[5]  = mkv(13'sd0,    1'b0, 1'b0, 2);
        tab[6]  = mkv(13'sh1000, 1'b0, 1'b1, 1);
        tab[7]  = mkv(13'sh0FFF, 1'b0, 1'b0, 3);
        tab[8]  = mkv(-13'sd1,   1'b0, 1'b1, 1);
        tab[9]  = mkv(13'sd7,    1'b0, 1'b0, 2);
        tab[10] = mkv(-13'sd50,  1'b0, 1'b1, 1);
        tab[11] = mkv(13'sd20,   1'b1, 1'b0, 3);

        // Reset state
        repeat (3) tick;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        tick;

        // Basic N=4
        do_start(4'd2);
        for (int k = 0; k < 4; k++) begin
            send_bit(tab[k].llr, tab[k].frz, 0, ug, ln);
            chk($sformatf("tab_u[%0d]", k), ug, tab[k].exp_u);
            chk($sformatf("tab_len[%0d]", k), ln, tab[k].exp_len);
            if (k == 1) begin
                read_ps(1, 0, b); chk("n4_ps1_0", b, 1);
                read_ps(1, 1, b); chk("n4_ps1_1", b, 0);
            end
            if (k == 2) begin
                read_ps(0, 0, b); chk("n4_ps0_0", b, 1);
            end
            if (k < 3) check_all;
        end
        check_all;

        // N=8 decision rules and update timing
        do_start(4'd3);
        for (int k = 4; k < 12; k++) begin
            send_bit(tab[k].llr, tab[k].frz, k % 2, ug, ln);
            chk($sformatf("tab_u[%0d]", k), ug, tab[k].exp_u);
            chk($sformatf("tab_len[%0d]", k), ln, tab[k].exp_len);
            check_all;
        end

        // n_log=0 acts as 1
        do_start(4'd0);
        for (int k = 0; k < 2; k++) begin
            r = 13'($urandom);
            send_bit(r, 1'b0, 0, ug, ln);
            check_all;
        end

        // Reset during UPD, then a clean N=4 decode
        do_start(4'd3);
        for (int k = 0; k < 3; k++) begin
            r = 13'($urandom);
            send_bit(r, 1'b0, 0, ug, ln);
        end
        handshake(-13'sd5, 1'b0, 0);
        chk("pre_rst_u_valid", u_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        tick;
        rst_n = 1'b1;
        tick;
        model_clear;
        check_all;
        do_start(4'd2);
        for (int k = 0; k < 4; k++) begin
            r = 13'($urandom);
            send_bit(r, 1'($urandom_range(0, 1)), $urandom_range(0, 2), ug, ln);
            check_all;
        end

        // N=512 random stress, requested as n_log=12
        do_start(4'd12);
        uv_base = uv_count;
        for (int k = 0; k < 512; k++) begin
            if (k == 100) begin
                start = 1'b1;
                n_log = 4'd1;
                tick;
                start = 1'b0;
                chk("mid_start_ready", llr_ready, 1);
                chk("mid_start_idx", u_idx, 99);
            end
            r = 13'($urandom);
            send_bit(r, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3), ug, ln);
            if (k != 511) begin
                t = trail_ones(k);
                check_stage(t);
                t = $urandom_range(0, NLM - 1);
                ln = $urandom_range(0, (1 << t) - 1);
                read_ps(t, ln, b);
                chk($sformatf("spot_ps[%0d][%0d]", t, ln), b, mps[t][ln]);
            end
        end
        #4;
        chk("u_valid_count", uv_count - uv_base, 512);
        #1;
        check_all;

        // Out-of-range reads
        read_ps(9, 0, b);   chk("oor_stage9", b, 0);
        read_ps(15, 3, b);  chk("oor_stage15", b, 0);
        read_ps(0, 1, b);   chk("oor_s0_j1", b, 0);
        for (int j = 4; j < 8; j++) begin
            read_ps(2, j, b);
            chk($sformatf("oor_s2_j%0d", j), b, 0);
        end

        finish_run;
    end

endmodule
